hd63701_stack_seq: RTL

HD63701_STACK_SEQ -- requirements
Module: hd63701_stack_seq

---
 rtl/hd63701_stack_seq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/hd63701_stack_seq.sv
// hd63701_stack_seq
//
// Stack-frame sequencer modelled on the HD63701 interrupt entry and return
// path. One bus master issues single-beat accesses:
//   * interrupt entry: push NB frame beats downward from the latched stack
//     pointer, then fetch a 16-bit vector (high byte, then low byte).
//   * return from interrupt: pull NB beats upward from latched SP + 1. The
//     first beat pulled lands in the highest frame slot.
//
// Bus handshake: while a beat is presented, AD/RW/DO stay constant. The
// beat completes on the rising CLKp edge where rdy=1. rdy=0 stretches the
// beat indefinitely. In IDLE and DONE no beat is presented and AD/RW/DO
// are 0.
//
// Ports
//   CLKp       clock, rising edge
//   RSTn       asynchronous active-low reset
//   start_int  begin interrupt entry (wins over start_rti; IDLE only)
//   start_rti  begin return from interrupt (IDLE only)
//   vsel       vector index, vector lives at VBASE + 2*vsel
//   sp_in      stack pointer sampled at start
//   frame_in   frame to push, beat k = frame_in[k*DW +: DW]
//   DI         read data, sampled when a read beat completes
//   rdy        beat accept
//   AD/RW/DO   bus address / 1=write / write data
//   busy       sequence in progress (not IDLE)
//   done       one-cycle completion pulse (DONE state)
//   sp_out     final stack pointer of the last completed sequence
//   frame_out  frame gathered by the last completed rti sequence
//   pc_out     vector fetched by the last completed int sequence
//   wrap       a stack beat address of the last sequence wrapped mod 2^AW
//   state_dbg  current FSM state encoding, for checkers

module hd63701_stack_seq #(
  parameter int              AW    = 16,
  parameter int              DW    = 8,
  parameter int              NB    = 7,
  parameter logic [AW-1:0]   VBASE = 16'hFFF0
) (
  input  logic               CLKp,
  input  logic               RSTn,
  input  logic               start_int,
  input  logic               start_rti,
  input  logic [3:0]         vsel,
  input  logic [AW-1:0]      sp_in,
  input  logic [NB*DW-1:0]   frame_in,
  input  logic [DW-1:0]      DI,
  input  logic               rdy,
  output logic [AW-1:0]      AD,
  output logic               RW,
  output logic [DW-1:0]      DO,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      sp_out,
  output logic [NB*DW-1:0]   frame_out,
  output logic [15:0]        pc_out,
  output logic               wrap,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    VHI  = 3'd2,
    VLO  = 3'd3,
    PULL = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [3:0] LAST = 4'(NB - 1);

  state_t                  state;
  state_t                  state_nxt;

  logic [AW-1:0]           sp_l;
  logic [NB*DW-1:0]        frame_l;
  logic [3:0]              vsel_l;
  logic [3:0]              beat;
  logic                    wrap_acc;
  logic [DW-1:0]           pc_hi;
  // Pulled slots 1..NB-1; slot 0 is always the final beat and is taken
  // straight from DI when the frame is committed.
  logic [(NB-1)*DW-1:0]    frame_sh;

  // One extra bit on the address arithmetic: the top bit is the
  // borrow/carry out of the AW-bit stack space.
  logic [AW:0]             push_ext;
  logic [AW:0]             pull_ext;
  logic [AW-1:0]           vec_addr;
  logic [3:0]              pull_slot;

  assign push_ext  = {1'b0, sp_l} - (AW+1)'(beat);
  assign pull_ext  = {1'b0, sp_l} + (AW+1)'(beat) + (AW+1)'(1);
  assign vec_addr  = VBASE + AW'({vsel_l, 1'b0});
  assign pull_slot = LAST - beat;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // State register
  always_ff @(posedge CLKp or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and bus outputs. Bus outputs depend only on registered
  // state, so they hold while rdy=0 and drop to 0 as soon as reset
  // forces IDLE.
  always_comb begin
    state_nxt = state;
    AD        = '0;
    RW        = 1'b0;
    DO        = '0;
    unique case (state)
      IDLE: begin
        if (start_int) begin
          state_nxt = PUSH;
        end else if (start_rti) begin
          state_nxt = PULL;
        end
      end
      PUSH: begin
        AD = push_ext[AW-1:0];
        RW = 1'b1;
        DO = frame_l[beat*DW +: DW];
        if (rdy && (beat == LAST)) begin
          state_nxt = VHI;
        end
      end
      VHI: begin
        AD = vec_addr;
        if (rdy) begin
          state_nxt = VLO;
        end
      end
      VLO: begin
        AD = vec_addr + AW'(1);
        if (rdy) begin
          state_nxt = DONE;
        end
      end
      PULL: begin
        AD = pull_ext[AW-1:0];
        if (rdy && (beat == LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. Result registers (sp_out, pc_out, frame_out, wrap) are only
  // written on the edge that enters DONE, so they keep the previous
  // sequence's results for the whole of the next sequence. wrap_acc is the
  // per-sequence accumulator that is cleared when a sequence starts.
  always_ff @(posedge CLKp or negedge RSTn) begin
    if (!RSTn) begin
      sp_l      <= '0;
      frame_l   <= '0;
      vsel_l    <= '0;
      beat      <= '0;
      wrap_acc  <= 1'b0;
      pc_hi     <= '0;
      frame_sh  <= '0;
      sp_out    <= '0;
      pc_out    <= '0;
      frame_out <= '0;
      wrap      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (start_int) begin
            sp_l     <= sp_in;
            frame_l  <= frame_in;
            vsel_l   <= vsel;
            wrap_acc <= 1'b0;
          end else if (start_rti) begin
            sp_l     <= sp_in;
            wrap_acc <= 1'b0;
          end
        end
        PUSH: begin
          if (rdy) begin
            if (push_ext[AW]) begin
              wrap_acc <= 1'b1;
            end
            beat <= (beat == LAST) ? 4'd0 : beat + 4'd1;
          end
        end
        VHI: begin
          if (rdy) begin
            pc_hi <= DI;
          end
        end
        VLO: begin
          if (rdy) begin
            pc_out <= 16'({pc_hi, DI});
            sp_out <= sp_l - AW'(NB);
            wrap   <= wrap_acc;
          end
        end
        PULL: begin
          if (rdy) begin
            if (pull_slot != 4'd0) begin
              frame_sh[(pull_slot - 4'd1)*DW +: DW] <= DI;
            end
            if (pull_ext[AW]) begin
              wrap_acc <= 1'b1;
            end
            if (beat == LAST) begin
              frame_out <= {frame_sh, DI};
              sp_out    <= sp_l + AW'(NB);
              wrap      <= wrap_acc | pull_ext[AW];
              beat      <= '0;
            end else begin
              beat <= beat + 4'd1;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
